regmem_req_port: RTL and testbench
==================================

Name: regmem_req_port

Overview:
- Request/response front-end that sits directly upstream of the single-port masked register memory (RegMemWm).
- Converts a valid/ready request channel into the memory's enable/writeEnable/writeMask/addr/writeData strobes.
- Absorbs the memory's one-cycle registered read latency with a small response skid FIFO, so a consumer can back-pressure read data without losing it.
- Sustains one request per cycle when the consumer is always ready.

Parameters:
- WIDTH, 16, data width; must equal the memory's WIDTH.
- HEIGHT, 16, number of words; address width is $clog2(HEIGHT).
- MASK, 4, write-mask width; passed through unchanged.
- RSP_DEPTH, 2, response FIFO entries; minimum 2, which is required for full throughput under stalls.

Ports:
- clk_i  in  1  clock; the block has one clock domain.
- reset_i  in  1  reset; asynchronous, active-high.
- reqValid_i  in  1  request valid.
- reqReady_o  out  1  request accepted when reqValid_i && reqReady_o.
- reqWrite_i  in  1  1 = write, 0 = read.
- reqMask_i  in  MASK  write mask; ignored for reads.
- reqAddr_i  in  $clog2(HEIGHT)  word address.
- reqWdata_i  in  WIDTH  write data.
- rspValid_o  out  1  read data valid.
- rspReady_i  in  1  consumer ready.
- rspRdata_o  out  WIDTH  read data.
- memEnable_o  out  1  to memory enable_i.
- memWriteEnable_o  out  1  to memory writeEnable_i.
- memWriteMask_o  out  MASK  to memory writeMask_i.
- memAddr_o  out  $clog2(HEIGHT)  to memory addr_i.
- memWriteData_o  out  WIDTH  to memory writeData_i.
- memReadData_i  in  WIDTH  from memory readData_o.

Behaviour:
Reset values:
- reqReady_o=1, rspValid_o=0, rspRdata_o=0 while the FIFO is empty and nothing is in flight.
- All mem* strobes 0.
- FIFO pointers and count 0, inflight 0.

Request acceptance:
- Let acc = reqValid_i && reqReady_o.
- Memory strobes are combinational from the request. Read: memEnable_o = acc && !reqWrite_i. Write: memWriteEnable_o = acc && reqWrite_i.
- memAddr_o, memWriteData_o and memWriteMask_o follow the request fields. memWriteMask_o is forced to 0 unless a write is accepted.
- The memory output register holds its value when enable is low. Read data is therefore valid only in the cycle immediately after the accepting cycle.

Inflight flag:
- inflight is set for one cycle after an accepted read (or, with the option enabled, an accepted write).
- Credit rule: reqReady_o = (count + inflight) < RSP_DEPTH.
- reqReady_o has no combinational path from rspReady_i or reqValid_i.

Response path (read latency 1):
- In the cycle with inflight=1 and count=0, the data bypasses the FIFO: rspValid_o=1, rspRdata_o=memReadData_i. If rspReady_i=0, the data is pushed into the FIFO at the clock edge.
- With count>0: rspValid_o=1, rspRdata_o=FIFO head. A returning inflight datum is pushed at the tail.
- Responses stay in strict request order.
- Pop when rspValid_o && rspReady_i. Push and pop in the same cycle leave count unchanged.
- Pointers wrap modulo RSP_DEPTH.
- rspRdata_o and rspValid_o are stable while rspValid_o && !rspReady_i.

Writes:
- A write takes effect at the accepting edge.
- A read accepted in the cycle after a write to the same address returns the new data.
- No response is produced (see option).

Full and empty:
- count+inflight == RSP_DEPTH gives reqReady_o=0.
- Overflow is impossible by construction. The bench asserts push && count==RSP_DEPTH never occurs.

Reset mid-operation:
- The FIFO and inflight are flushed immediately; pending responses are dropped.
- All mem* strobes are driven 0 during reset.
- Memory contents are unaffected.

Optional Feature:
- Macro: REGMEM_REQ_PORT_WRITE_ACK_EN.
- Defined: every accepted write also consumes a credit, sets inflight, and returns one in-order response with rspRdata_o = 0. Writers can use this to detect completion.
- Undefined: writes consume no credit and produce no response; only reads return data.

Test Plan:
- Reset released, write addr 3 data 16'hA5C3 mask 4'b1111, then read addr 3 with rspReady_i=1 -> rspValid_o=1 one cycle after the read is accepted, rspRdata_o=16'hA5C3.
- Mem word 5 = 16'hFFFF, write 16'h1234 mask 4'b0101, read 5 -> 16'hF2F4.
- Back-to-back reads of addr 0..7, rspReady_i=1 constant -> reqReady_o held 1, 8 responses in 8 consecutive cycles, in order.
- Read addr 1,2 back-to-back with rspReady_i=0 -> reqReady_o drops to 0 after the second read. Both data held; rspRdata_o stable. Then rspReady_i=1 -> addr 1 data then addr 2 data, and reqReady_o returns to 1.
- Read accepted, reset_i asserted the next cycle with rspReady_i=0 -> rspValid_o=0, reqReady_o=1 after reset, no stale response afterwards.
- With REGMEM_REQ_PORT_WRITE_ACK_EN: write then read addr 9 -> two responses, first rspRdata_o=0, second the written value. Without it: only one response.

Source files
------------

// File: rtl/regmem_req_port.sv
// Valid/ready request front-end for the single-port masked register memory, with an in-order response skid FIFO.
// Define REGMEM_REQ_PORT_WRITE_ACK_EN to make every accepted write return a zero-data response.
module regmem_req_port #(
   parameter int WIDTH     = 16,
   parameter int HEIGHT    = 16,
   parameter int MASK      = 4,
   parameter int RSP_DEPTH = 2,
   localparam int ADDR_W   = $clog2(HEIGHT)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              reqValid_i,
   output logic              reqReady_o,
   input  logic              reqWrite_i,
   input  logic [MASK-1:0]   reqMask_i,
   input  logic [ADDR_W-1:0] reqAddr_i,
   input  logic [WIDTH-1:0]  reqWdata_i,
   output logic              rspValid_o,
   input  logic              rspReady_i,
   output logic [WIDTH-1:0]  rspRdata_o,
   output logic              memEnable_o,
   output logic              memWriteEnable_o,
   output logic [MASK-1:0]   memWriteMask_o,
   output logic [ADDR_W-1:0] memAddr_o,
   output logic [WIDTH-1:0]  memWriteData_o,
   input  logic [WIDTH-1:0]  memReadData_i
);

   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);
   localparam int CRD_W = CNT_W + 1;

   logic [CNT_W-1:0] count_reg, count_next;
   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic             inflight_reg, inflight_next;
   logic             inflight_wr_reg, inflight_wr_next;
   logic [WIDTH-1:0] fifo_mem [RSP_DEPTH];

   logic [CRD_W-1:0] credit_used;
   logic             req_ready;
   logic             acc;
   logic             track_req;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;
   logic [WIDTH-1:0] rsp_in_data;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Credit counts both stored responses and the one still coming out of the memory,
   // so ready depends only on registered state.
   assign credit_used = CRD_W'(count_reg) + CRD_W'(inflight_reg);
   assign req_ready   = credit_used < CRD_W'(RSP_DEPTH);
   assign reqReady_o  = req_ready;

   assign acc = reqValid_i && req_ready && !reset_i;

   assign memEnable_o      = acc && !reqWrite_i;
   assign memWriteEnable_o = acc && reqWrite_i;
   assign memWriteMask_o   = (acc && reqWrite_i) ? reqMask_i : '0;
   assign memAddr_o        = reset_i ? '0 : reqAddr_i;
   assign memWriteData_o   = reset_i ? '0 : reqWdata_i;

`ifdef REGMEM_REQ_PORT_WRITE_ACK_EN
   assign track_req        = acc;
   assign inflight_wr_next = acc && reqWrite_i;
`else
   assign track_req        = acc && !reqWrite_i;
   assign inflight_wr_next = 1'b0;
`endif

   assign inflight_next = track_req;
   assign rsp_in_data   = inflight_wr_reg ? '0 : memReadData_i;
   assign fifo_empty    = (count_reg == '0);

   // Returning data bypasses the FIFO when it is empty; otherwise the head is shown.
   assign rspValid_o = !fifo_empty || inflight_reg;
   assign rspRdata_o = !fifo_empty   ? fifo_mem[rd_ptr_reg] :
                       inflight_reg  ? rsp_in_data : '0;

   assign fifo_push = inflight_reg && !(fifo_empty && rspReady_i);
   assign fifo_pop  = !fifo_empty && rspReady_i;

   always_comb begin
      count_next  = count_reg;
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      if (fifo_push) begin
         wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      if (fifo_pop) begin
         rd_ptr_next = ptr_inc(rd_ptr_reg);
      end
      case ({fifo_push, fifo_pop})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         count_reg       <= '0;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         inflight_reg    <= 1'b0;
         inflight_wr_reg <= 1'b0;
      end else begin
         count_reg       <= count_next;
         wr_ptr_reg      <= wr_ptr_next;
         rd_ptr_reg      <= rd_ptr_next;
         inflight_reg    <= inflight_next;
         inflight_wr_reg <= inflight_wr_next;
      end
   end

   // Storage needs no reset: entries are only visible through count_reg.
   always_ff @(posedge clk_i) begin
      if (fifo_push) begin
         fifo_mem[wr_ptr_reg] <= rsp_in_data;
      end
   end

endmodule

// File: tb/tb_regmem_req_port.sv
// Directed bench for regmem_req_port with a behavioural masked memory attached to the mem* side.
// Expectations follow REGMEM_REQ_PORT_WRITE_ACK_EN when it is defined.
module tb_regmem_req_port;

`ifdef REGMEM_REQ_PORT_WRITE_ACK_EN
   localparam bit ACK = 1'b1;
`else
   localparam bit ACK = 1'b0;
`endif
   localparam int RSP_DEPTH = 2;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        reqValid_i, reqReady_o, reqWrite_i;
   logic [3:0]  reqMask_i;
   logic [3:0]  reqAddr_i;
   logic [15:0] reqWdata_i;
   logic        rspValid_o, rspReady_i;
   logic [15:0] rspRdata_o;
   logic        memEnable_o, memWriteEnable_o;
   logic [3:0]  memWriteMask_o;
   logic [3:0]  memAddr_o;
   logic [15:0] memWriteData_o;
   logic [15:0] memReadData_i;

   int n_assert = 0;
   int n_fail   = 0;

   regmem_req_port #(.WIDTH(16), .HEIGHT(16), .MASK(4), .RSP_DEPTH(RSP_DEPTH)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .reqValid_i(reqValid_i), .reqReady_o(reqReady_o), .reqWrite_i(reqWrite_i),
      .reqMask_i(reqMask_i), .reqAddr_i(reqAddr_i), .reqWdata_i(reqWdata_i),
      .rspValid_o(rspValid_o), .rspReady_i(rspReady_i), .rspRdata_o(rspRdata_o),
      .memEnable_o(memEnable_o), .memWriteEnable_o(memWriteEnable_o),
      .memWriteMask_o(memWriteMask_o), .memAddr_o(memAddr_o),
      .memWriteData_o(memWriteData_o), .memReadData_i(memReadData_i)
   );

   always #5 clk_i = ~clk_i;

   // Masked register memory: one mask bit per nibble, registered read that holds when disabled.
   logic [15:0] mem_model [16];
   always @(posedge clk_i) begin
      if (memWriteEnable_o)
         for (int i = 0; i < 4; i++)
            if (memWriteMask_o[i]) mem_model[memAddr_o][i*4 +: 4] <= memWriteData_o[i*4 +: 4];
      if (memEnable_o) memReadData_i <= mem_model[memAddr_o];
   end

   always @(negedge clk_i) begin
      if (!reset_i) begin
         n_assert++;
         assert (!(dut.fifo_push && dut.count_reg == RSP_DEPTH)) else begin
            n_fail++;
            $error("FAIL overflow: observed push with count %0d required no push", dut.count_reg);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic w, input logic [3:0] m,
                        input logic [3:0] a, input logic [15:0] d, input logic rr);
      @(negedge clk_i);
      reqValid_i = v; reqWrite_i = w; reqMask_i = m;
      reqAddr_i = a; reqWdata_i = d; rspReady_i = rr;
      #1;
      $display("t=%0t req v=%0b w=%0b addr=%0d data=%h mask=%b rr=%0b | ready=%0b rsp v=%0b d=%h",
               $time, v, w, a, d, m, rr, reqReady_o, rspValid_o, rspRdata_o);
   endtask

   logic [15:0] vals [8];
   int          n_rsp;
   logic [15:0] first_rsp, last_rsp;

   initial begin
      for (int i = 0; i < 16; i++) mem_model[i] = 16'h0000;
      memReadData_i = 16'h0000;
      for (int k = 0; k < 8; k++) vals[k] = 16'h1000 + 16'(k) * 16'h0111;
      reset_i = 1'b1; reqValid_i = 1'b0; reqWrite_i = 1'b0; reqMask_i = 4'h0;
      reqAddr_i = 4'h0; reqWdata_i = 16'h0; rspReady_i = 1'b0;

      // Reset state
      repeat (2) @(negedge clk_i);
      #1;
      chk("rst_ready", reqReady_o, 1);
      chk("rst_rspvalid", rspValid_o, 0);
      chk("rst_rdata", rspRdata_o, 0);
      chk("rst_memen", memEnable_o, 0);
      chk("rst_memwe", memWriteEnable_o, 0);
      chk("rst_memmask", memWriteMask_o, 0);
      reqValid_i = 1'b1; reqWrite_i = 1'b1; reqMask_i = 4'hF; #1;
      chk("rst_gate_we", memWriteEnable_o, 0);
      chk("rst_gate_mask", memWriteMask_o, 0);
      @(negedge clk_i);
      reset_i = 1'b0; reqValid_i = 1'b0; reqWrite_i = 1'b0; reqMask_i = 4'h0;

      // Write then read addr 3
      drive(1, 1, 4'hF, 4'd3, 16'hA5C3, 1);
      chk("t1_we", memWriteEnable_o, 1);
      chk("t1_en_wr", memEnable_o, 0);
      chk("t1_mask", memWriteMask_o, 4'hF);
      chk("t1_addr", memAddr_o, 3);
      chk("t1_wdata", memWriteData_o, 16'hA5C3);
      drive(1, 0, 4'hF, 4'd3, 16'h0000, 1);
      chk("t1_en_rd", memEnable_o, 1);
      chk("t1_mask_rd", memWriteMask_o, 0);
      chk("t1_ack_valid", rspValid_o, ACK);
      drive(0, 0, 4'h0, 4'd0, 16'h0000, 1);
      chk("t1_rsp_valid", rspValid_o, 1);
      chk("t1_rsp_data", rspRdata_o, 16'hA5C3);
      drive(0, 0, 4'h0, 4'd0, 16'h0000, 1);
      chk("t1_idle", rspValid_o, 0);

      // Masked write
      drive(1, 1, 4'hF, 4'd5, 16'hFFFF, 1);
      drive(1, 1, 4'b0101, 4'd5, 16'h1234, 1);
      drive(1, 0, 4'h0, 4'd5, 16'h0000, 1);
      drive(0, 0, 4'h0, 4'd0, 16'h0000, 1);
      chk("t2_valid", rspValid_o, 1);
      chk("t2_data", rspRdata_o, 16'hF2F4);

      // Back-to-back reads of 0..7
      for (int k = 0; k < 8; k++) drive(1, 1, 4'hF, 4'(k), vals[k], 1);
      for (int k = 0; k < 8; k++) begin
         drive(1, 0, 4'h0, 4'(k), 16'h0000, 1);
         chk("t3_ready", reqReady_o, 1);
         if (k > 0) begin
            chk("t3_valid", rspValid_o, 1);
            chk("t3_data", rspRdata_o, vals[k-1]);
         end
      end
      drive(0, 0, 4'h0, 4'd0, 16'h0000, 1);
      chk("t3_last_valid", rspValid_o, 1);
      chk("t3_last_data", rspRdata_o, vals[7]);
      drive(0, 0, 4'h0, 4'd0, 16'h0000, 0);
      chk("t3_drained", rspValid_o, 0);

      // Stall with two reads outstanding
      drive(1, 0, 4'h0, 4'd1, 16'h0000, 0);
      chk("t4_ready_a", reqReady_o, 1);
      drive(1, 0, 4'h0, 4'd2, 16'h0000, 0);
      chk("t4_ready_b", reqReady_o, 1);
      chk("t4_data_b", rspRdata_o, vals[1]);
      drive(1, 0, 4'h0, 4'd7, 16'h0000, 0);
      chk("t4_ready_c", reqReady_o, 0);
      chk("t4_noen_c", memEnable_o, 0);
      chk("t4_data_c", rspRdata_o, vals[1]);
      drive(1, 0, 4'h0, 4'd7, 16'h0000, 0);
      chk("t4_ready_d", reqReady_o, 0);
      chk("t4_noen_d", memEnable_o, 0);
      chk("t4_valid_d", rspValid_o, 1);
      chk("t4_data_d", rspRdata_o, vals[1]);
      drive(0, 0, 4'h0, 4'd0, 16'h0000, 1);
      chk("t4_data_e", rspRdata_o, vals[1]);
      chk("t4_ready_e", reqReady_o, 0);
      drive(0, 0, 4'h0, 4'd0, 16'h0000, 1);
      chk("t4_valid_f", rspValid_o, 1);
      chk("t4_data_f", rspRdata_o, vals[2]);
      chk("t4_ready_f", reqReady_o, 1);
      drive(0, 0, 4'h0, 4'd0, 16'h0000, 1);
      chk("t4_valid_g", rspValid_o, 0);

      // Reset with a read in flight
      drive(1, 0, 4'h0, 4'd4, 16'h0000, 0);
      @(negedge clk_i);
      reset_i = 1'b1; reqValid_i = 1'b1; reqWrite_i = 1'b0; #1;
      chk("t5_rst_valid", rspValid_o, 0);
      chk("t5_rst_ready", reqReady_o, 1);
      chk("t5_rst_memen", memEnable_o, 0);
      @(negedge clk_i);
      reset_i = 1'b0; reqValid_i = 1'b0; #1;
      chk("t5_post_valid", rspValid_o, 0);
      drive(0, 0, 4'h0, 4'd0, 16'h0000, 1);
      chk("t5_no_stale", rspValid_o, 0);
      drive(1, 0, 4'h0, 4'd4, 16'h0000, 1);
      drive(0, 0, 4'h0, 4'd0, 16'h0000, 1);
      chk("t5_mem_kept", rspRdata_o, vals[4]);

      // Write then read addr 9, counting responses
      drive(1, 1, 4'hF, 4'd9, 16'hBEEF, 1);
      chk("t6_wr_valid", rspValid_o, 0);
      n_rsp = 0; first_rsp = 16'h0; last_rsp = 16'h0;
      for (int c = 0; c < 4; c++) begin
         if (c == 0) drive(1, 0, 4'h0, 4'd9, 16'h0000, 1);
         else        drive(0, 0, 4'h0, 4'd0, 16'h0000, 1);
         if (rspValid_o) begin
            n_rsp++;
            if (n_rsp == 1) first_rsp = rspRdata_o;
            last_rsp = rspRdata_o;
         end
      end
      chk("t6_count", n_rsp, ACK ? 2 : 1);
      chk("t6_first", first_rsp, ACK ? 16'h0000 : 16'hBEEF);
      chk("t6_last", last_rsp, 16'hBEEF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
